frame_plotter: RTL and testbench

FRAME_PLOTTER -- requirements
Module: frame_plotter

---
 rtl/gfx_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 69 ++++++
 rtl/frame_plotter.sv | 205 ++++++++++++++++++++
 tb/tb_frame_plotter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the frame plotter: FSM state encoding, the pixel
// record carried through the input FIFO, and the default geometry.
package gfx_pkg;

    localparam int DEF_H_RES   = 320;
    localparam int DEF_V_RES   = 240;
    localparam int DEF_COLOR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLEAR = 2'd2
    } plot_state_e;

    // Pixel record at the default colour width; the plotter builds the same
    // layout at its own COLOR_W.
    typedef struct packed {
        logic signed [31:0]     x;
        logic signed [31:0]     y;
        logic [DEF_COLOR_W-1:0] color;
        logic                   last;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for incoming pixels. A push is taken when there is
// room or when a pop frees a slot in the same cycle, so a full FIFO can
// stream without loss or duplication.
module pixel_fifo
    import gfx_pkg::*;
#(
    parameter int W     = $bits(pixel_t),
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_plotter.sv
// Frame plotter: accepts pixels from a drawer, clips them to the framebuffer,
// and issues linear-address writes; can also clear the whole frame.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (pix_valid/pix_ready in, fb_we/fb_ready out); a pending fb write
// holds address and data unchanged until it is taken.
// Pipeline: FIFO -> stage 1 (clip + address) -> output write register.
module frame_plotter
    import gfx_pkg::*;
#(
    parameter int                 H_RES    = DEF_H_RES,
    parameter int                 V_RES    = DEF_V_RES,
    parameter int                 COLOR_W  = DEF_COLOR_W,
    parameter int                 ADDR_W   = 18,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic signed [31:0]  pix_x,
    input  logic signed [31:0]  pix_y,
    input  logic [COLOR_W-1:0]  pix_color,
    input  logic                pix_last,
    input  logic                clear_start,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]  fb_wdata,
    input  logic                fb_ready,
    output logic                busy,
    output logic                prim_done,
    output logic [31:0]         plotted_cnt,
    output logic [31:0]         clipped_cnt,
    output logic [1:0]          dbg_state
);

    // Same layout as gfx_pkg::pixel_t, sized for this instance's COLOR_W.
    typedef struct packed {
        logic signed [31:0]   x;
        logic signed [31:0]   y;
        logic [COLOR_W-1:0]   color;
        logic                 last;
    } pix_rec_t;

    localparam int NPIX = H_RES * V_RES;

    pix_rec_t push_rec, pop_rec;
    logic     fifo_full, fifo_empty, push, pop;

    plot_state_e         state_q, state_d;
    logic                s1_valid_q, s1_valid_d, s1_clip_q, s1_clip_d;
    logic                s1_last_q, s1_last_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic [COLOR_W-1:0]  s1_color_q, s1_color_d;
    logic                fb_we_q, fb_we_d, fb_last_q, fb_last_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]  fb_wdata_q, fb_wdata_d;
    logic [31:0]         plotted_q, plotted_d, clipped_q, clipped_d;
    logic                prim_done_q, prim_done_d;

    logic              in_range, out_free, retire, s1_adv;
    logic [ADDR_W-1:0] lin_addr;

    assign pix_ready = rst_n && !fifo_full && (state_q != ST_CLEAR);
    assign push      = pix_valid && pix_ready;
    assign push_rec  = '{x: pix_x, y: pix_y, color: pix_color, last: pix_last};

    pixel_fifo #(.W($bits(pix_rec_t)), .DEPTH(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_rec),
        .pop   (pop),
        .dout  (pop_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_range = (pop_rec.x >= 0) && (pop_rec.x < H_RES) &&
                      (pop_rec.y >= 0) && (pop_rec.y < V_RES);
    assign lin_addr = ADDR_W'($unsigned(pop_rec.y) * $unsigned(H_RES) + $unsigned(pop_rec.x));

    assign retire   = fb_we_q && fb_ready;
    assign out_free = !fb_we_q || fb_ready;
    assign s1_adv   = s1_valid_q && out_free;
    assign pop      = !fifo_empty && (!s1_valid_q || s1_adv);

    // Next-state: pipeline advance, counters, clear sequencing and FSM.
    always_comb begin
        state_d     = state_q;
        s1_valid_d  = s1_valid_q;
        s1_clip_d   = s1_clip_q;
        s1_last_d   = s1_last_q;
        s1_addr_d   = s1_addr_q;
        s1_color_d  = s1_color_q;
        fb_we_d     = fb_we_q;
        fb_last_d   = fb_last_q;
        fb_addr_d   = fb_addr_q;
        fb_wdata_d  = fb_wdata_q;
        plotted_d   = plotted_q;
        clipped_d   = clipped_q;
        prim_done_d = 1'b0;

        if (retire) begin
            fb_we_d = 1'b0;
            if (state_q == ST_DRAW) begin
                if (plotted_q != '1) plotted_d = plotted_q + 1'b1;
                if (fb_last_q) prim_done_d = 1'b1;
            end
        end

        if (s1_adv) begin
            s1_valid_d = 1'b0;
            if (s1_clip_q) begin
                if (clipped_q != '1) clipped_d = clipped_q + 1'b1;
                if (s1_last_q) prim_done_d = 1'b1;
            end else begin
                fb_we_d    = 1'b1;
                fb_addr_d  = s1_addr_q;
                fb_wdata_d = s1_color_q;
                fb_last_d  = s1_last_q;
            end
        end

        if (pop) begin
            s1_valid_d = 1'b1;
            s1_clip_d  = !in_range;
            s1_addr_d  = lin_addr;
            s1_color_d = pop_rec.color;
            s1_last_d  = pop_rec.last;
        end

        case (state_q)
            ST_IDLE: begin
                // A pixel accepted this cycle wins; a clear request then is dropped.
                if (push) begin
                    state_d = ST_DRAW;
                end else if (clear_start) begin
                    state_d    = ST_CLEAR;
                    fb_we_d    = 1'b1;
                    fb_addr_d  = '0;
                    fb_wdata_d = BG_COLOR;
                    fb_last_d  = 1'b0;
                end
            end
            ST_DRAW: begin
                if (fifo_empty && !s1_valid_q && !fb_we_q && !pix_valid) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                // fb_addr_q doubles as the clear position.
                if (retire) begin
                    if (fb_addr_q == ADDR_W'(NPIX - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = fb_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_clip_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_addr_q   <= '0;
            s1_color_q  <= '0;
            fb_we_q     <= 1'b0;
            fb_last_q   <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= '0;
            plotted_q   <= '0;
            clipped_q   <= '0;
            prim_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_clip_q   <= s1_clip_d;
            s1_last_q   <= s1_last_d;
            s1_addr_q   <= s1_addr_d;
            s1_color_q  <= s1_color_d;
            fb_we_q     <= fb_we_d;
            fb_last_q   <= fb_last_d;
            fb_addr_q   <= fb_addr_d;
            fb_wdata_q  <= fb_wdata_d;
            plotted_q   <= plotted_d;
            clipped_q   <= clipped_d;
            prim_done_q <= prim_done_d;
        end
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign prim_done   = prim_done_q;
    assign plotted_cnt = plotted_q;
    assign clipped_cnt = clipped_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_plotter.sv
// Bench for frame_plotter: a default-geometry instance for drawing and a
// 4x2 instance for frame clears.
module tb_frame_plotter;
    import gfx_pkg::*;

    localparam int AW = 18, CW = 8, H = 320, V = 240, EW = AW + CW;
    localparam logic [CW-1:0] S_BG = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_n, s_rst_n;

    // ---------------- default instance ----------------
    logic               pix_valid, pix_ready, pix_last, clear_start;
    logic signed [31:0] pix_x, pix_y;
    logic [CW-1:0]      pix_color, fb_wdata;
    logic               fb_we, fb_ready, busy, prim_done;
    logic [AW-1:0]      fb_addr;
    logic [31:0]        plotted_cnt, clipped_cnt;
    logic [1:0]         dbg_state;

    frame_plotter #(.H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_last(pix_last),
        .clear_start(clear_start), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_ready(fb_ready), .busy(busy), .prim_done(prim_done),
        .plotted_cnt(plotted_cnt), .clipped_cnt(clipped_cnt), .dbg_state(dbg_state)
    );

    // ---------------- small instance (4x2) ----------------
    logic               s_pix_valid, s_pix_ready, s_pix_last, s_clear_start;
    logic signed [31:0] s_pix_x, s_pix_y;
    logic [CW-1:0]      s_pix_color, s_fb_wdata;
    logic               s_fb_we, s_fb_ready, s_busy, s_prim_done;
    logic [AW-1:0]      s_fb_addr;
    logic [31:0]        s_plotted_cnt, s_clipped_cnt;
    logic [1:0]         s_dbg_state;

    frame_plotter #(.H_RES(4), .V_RES(2), .COLOR_W(CW), .ADDR_W(AW), .BG_COLOR(S_BG)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_color(s_pix_color), .pix_last(s_pix_last),
        .clear_start(s_clear_start), .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_wdata(s_fb_wdata),
        .fb_ready(s_fb_ready), .busy(s_busy), .prim_done(s_prim_done),
        .plotted_cnt(s_plotted_cnt), .clipped_cnt(s_clipped_cnt), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0, n_errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] s_exp_q[$];
    int wr_cnt = 0, s_wr_cnt = 0;
    int exp_plotted = 0, exp_clipped = 0;

    logic          stall_prev = 1'b0, s_stall_prev = 1'b0;
    logic [EW-1:0] stall_val, s_stall_val, mon_e, s_mon_e;

    // Default instance: write order/content and hold-while-stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (fb_we !== 1'b1 || {fb_addr, fb_wdata} !== stall_val) begin
                    n_errors++;
                    $display("FAIL hold: got we=%0b addr/data=%h expected we=1 %h", fb_we, {fb_addr, fb_wdata}, stall_val);
                end
            end
            stall_prev = fb_we && !fb_ready;
            stall_val  = {fb_addr, fb_wdata};
            if (fb_we && fb_ready) begin
                wr_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h expected no write", fb_addr, fb_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({fb_addr, fb_wdata} !== mon_e) begin
                        n_errors++;
                        $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 fb_addr, fb_wdata, mon_e[EW-1:CW], mon_e[CW-1:0]);
                    end
                end
            end
        end
    end

    // Small instance: same checks.
    always @(negedge clk) begin
        if (!s_rst_n) begin
            s_stall_prev = 1'b0;
        end else begin
            if (s_stall_prev) begin
                n_checks++;
                if (s_fb_we !== 1'b1 || {s_fb_addr, s_fb_wdata} !== s_stall_val) begin
                    n_errors++;
                    $display("FAIL s_hold: got we=%0b addr/data=%h expected we=1 %h", s_fb_we, {s_fb_addr, s_fb_wdata}, s_stall_val);
                end
            end
            s_stall_prev = s_fb_we && !s_fb_ready;
            s_stall_val  = {s_fb_addr, s_fb_wdata};
            if (s_fb_we && s_fb_ready) begin
                s_wr_cnt++;
                n_checks++;
                if (s_exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL s_write_unexpected: got addr=%0d data=%h expected no write", s_fb_addr, s_fb_wdata);
                end else begin
                    s_mon_e = s_exp_q.pop_front();
                    if ({s_fb_addr, s_fb_wdata} !== s_mon_e) begin
                        n_errors++;
                        $display("FAIL s_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 s_fb_addr, s_fb_wdata, s_mon_e[EW-1:CW], s_mon_e[CW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Offers one pixel and returns 1 time unit after the edge that accepts it.
    task automatic send_pixel(input int x, input int y, input logic [CW-1:0] c,
                              input logic last, output int waited);
        waited    = 0;
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_color = c;
        pix_last  = last;
        if (x >= 0 && x < H && y >= 0 && y < V) begin
            exp_q.push_back({AW'(y * H + x), c});
            exp_plotted++;
        end else begin
            exp_clipped++;
        end
        forever begin
            @(negedge clk);
            if (pix_ready) break;
            waited++;
            if (waited > 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got pix_ready=0 for %0d cycles expected acceptance", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fb_we !== 1'b0) begin n_errors++; $display("FAIL reset_fb_we: got %0b expected 0", fb_we); end
        n_checks++; if (fb_addr !== '0) begin n_errors++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        n_checks++; if (fb_wdata !== '0) begin n_errors++; $display("FAIL reset_fb_wdata: got %h expected 0", fb_wdata); end
        n_checks++; if (pix_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pix_ready: got %0b expected 0", pix_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (prim_done !== 1'b0) begin n_errors++; $display("FAIL reset_prim_done: got %0b expected 0", prim_done); end
        n_checks++; if (plotted_cnt !== 32'd0 || clipped_cnt !== 32'd0) begin
            n_errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", plotted_cnt, clipped_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (pix_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %0b expected 1", pix_ready); end
        n_checks++; if (dbg_state !== 2'(ST_IDLE)) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pixel();
        int w;
        fb_ready = 1'b1;
        send_pixel(10, 20, 8'h5A, 1'b1, w);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
        @(posedge clk); #1;
        n_checks++; if (fb_we !== 1'b0) begin n_errors++; $display("FAIL single_early_we: got %0b expected 0", fb_we); end
        @(posedge clk); #1;
        n_checks++; if (fb_we !== 1'b1 || fb_addr !== AW'(6410) || fb_wdata !== 8'h5A) begin
            n_errors++; $display("FAIL single_write: got we=%0b addr=%0d data=%h expected we=1 addr=6410 data=5a", fb_we, fb_addr, fb_wdata); end
        @(posedge clk); #1;
        n_checks++; if (plotted_cnt !== 32'd1) begin n_errors++; $display("FAIL single_plotted: got %0d expected 1", plotted_cnt); end
        n_checks++; if (prim_done !== 1'b1) begin n_errors++; $display("FAIL single_prim_done: got %0b expected 1", prim_done); end
        @(posedge clk); #1;
        n_checks++; if (prim_done !== 1'b0) begin n_errors++; $display("FAIL single_prim_done_width: got %0b expected 0", prim_done); end
        wait_idle();
    endtask

    task automatic test_clipping();
        int w, pulses = 0, wr0 = wr_cnt;
        fb_ready = 1'b1;
        send_pixel(-1, 5, 8'h11, 1'b0, w);
        send_pixel(320, 0, 8'h22, 1'b0, w);
        send_pixel(5, 240, 8'h33, 1'b1, w);
        repeat (12) begin
            @(negedge clk);
            if (prim_done) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL clip_prim_done: got %0d pulses expected 1", pulses); end
        n_checks++; if (clipped_cnt !== 32'(exp_clipped)) begin n_errors++; $display("FAIL clip_count: got %0d expected %0d", clipped_cnt, exp_clipped); end
        n_checks++; if (wr_cnt != wr0) begin n_errors++; $display("FAIL clip_writes: got %0d writes expected 0", wr_cnt - wr0); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int w, stall_at = -1, wr0 = wr_cnt;
        fb_ready = 1'b0;
        fork
            begin
                for (int i = 0; i <= 20; i++) begin
                    send_pixel(10 + i, 20 + i, CW'(i * 7 + 3), (i == 20), w);
                    if (w > 0 && stall_at < 0) stall_at = i;
                end
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                fb_ready = 1'b1;
            end
        join
        wait_idle();
        n_checks++; if (stall_at != 6) begin n_errors++; $display("FAIL bp_ready_drop: got stall after %0d accepts expected 6", stall_at); end
        n_checks++; if (wr_cnt - wr0 != 21) begin n_errors++; $display("FAIL bp_writes: got %0d expected 21", wr_cnt - wr0); end
        n_checks++; if (plotted_cnt !== 32'(exp_plotted)) begin n_errors++; $display("FAIL bp_plotted: got %0d expected %0d", plotted_cnt, exp_plotted); end
    endtask

    task automatic test_back_to_back();
        int w, start;
        fb_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            send_pixel(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
                       CW'($urandom_range(0, 255)), (i == 7), w);
        end
        n_checks++; if (cyc - start != 8) begin n_errors++; $display("FAIL b2b_rate: got %0d cycles expected 8", cyc - start); end
        wait_idle();
        n_checks++; if (plotted_cnt !== 32'(exp_plotted)) begin n_errors++; $display("FAIL b2b_plotted: got %0d expected %0d", plotted_cnt, exp_plotted); end
    endtask

    task automatic test_random_mix();
        int w;
        logic drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send_pixel(int'($urandom_range(0, 335)) - 5, int'($urandom_range(0, 250)) - 5,
                               CW'($urandom_range(0, 255)), (i == 29), w);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    fb_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        fb_ready = 1'b1;
        wait_idle();
        n_checks++; if (plotted_cnt !== 32'(exp_plotted) || clipped_cnt !== 32'(exp_clipped)) begin
            n_errors++; $display("FAIL rand_counts: got %0d/%0d expected %0d/%0d", plotted_cnt, clipped_cnt, exp_plotted, exp_clipped); end
    endtask

    task automatic test_clear_in_draw();
        int w, wr0 = wr_cnt;
        fb_ready = 1'b1;
        send_pixel(50, 60, 8'hC3, 1'b1, w);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (wr_cnt - wr0 != 1) begin n_errors++; $display("FAIL draw_clear_writes: got %0d expected 1", wr_cnt - wr0); end
        n_checks++; if (dbg_state !== 2'(ST_IDLE) || busy !== 1'b0) begin
            n_errors++; $display("FAIL draw_clear_state: got state=%0d busy=%0b expected state=0 busy=0", dbg_state, busy); end
    endtask

    task automatic test_clear();
        int t = 0, wr0 = s_wr_cnt;
        for (int a = 0; a < 8; a++) s_exp_q.push_back({AW'(a), S_BG});
        s_clear_start = 1'b1;
        @(posedge clk); #1;
        s_clear_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!s_busy) break;
            n_checks++; if (s_pix_ready !== 1'b0) begin n_errors++; $display("FAIL clear_pix_ready: got %0b expected 0", s_pix_ready); end
            t++;
            if (t > 100) begin n_checks++; n_errors++; $display("FAIL clear_timeout: got busy=1 expected busy=0"); break; end
            @(posedge clk); #1;
            s_fb_ready = ($urandom_range(0, 1) != 0);
        end
        s_fb_ready = 1'b1;
        n_checks++; if (s_wr_cnt - wr0 != 8 || s_exp_q.size() != 0) begin
            n_errors++; $display("FAIL clear_writes: got %0d pending=%0d expected 8 pending=0", s_wr_cnt - wr0, s_exp_q.size()); end
        n_checks++; if (s_plotted_cnt !== 32'd0) begin n_errors++; $display("FAIL clear_plotted: got %0d expected 0", s_plotted_cnt); end
        n_checks++; if (s_dbg_state !== 2'(ST_IDLE)) begin n_errors++; $display("FAIL clear_end_state: got %0d expected 0", s_dbg_state); end
    endtask

    task automatic test_reset_mid_clear();
        int t = 0;
        logic found = 1'b0;
        s_fb_ready  = 1'b1;
        s_pix_valid = 1'b1; s_pix_x = -1; s_pix_y = 0; s_pix_color = 8'h01; s_pix_last = 1'b0;
        @(posedge clk); #1;
        s_pix_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (s_clipped_cnt !== 32'd1) begin n_errors++; $display("FAIL rmc_pre_clip: got %0d expected 1", s_clipped_cnt); end
        for (int a = 0; a < 8; a++) s_exp_q.push_back({AW'(a), S_BG});
        s_clear_start = 1'b1;
        @(posedge clk); #1;
        s_clear_start = 1'b0;
        while (!found && t < 50) begin
            @(negedge clk);
            if (s_fb_we && s_fb_addr == AW'(3)) found = 1'b1;
            t++;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL rmc_reach_addr3: got addr=%0d expected 3", s_fb_addr); end
        #2;
        s_rst_n = 1'b0;
        #1;
        n_checks++; if (s_fb_we !== 1'b0 || s_fb_addr !== '0) begin
            n_errors++; $display("FAIL rmc_fb: got we=%0b addr=%0d expected we=0 addr=0", s_fb_we, s_fb_addr); end
        n_checks++; if (s_plotted_cnt !== 32'd0 || s_clipped_cnt !== 32'd0) begin
            n_errors++; $display("FAIL rmc_counters: got %0d/%0d expected 0/0", s_plotted_cnt, s_clipped_cnt); end
        n_checks++; if (s_dbg_state !== 2'(ST_IDLE) || s_busy !== 1'b0 || s_pix_ready !== 1'b0) begin
            n_errors++; $display("FAIL rmc_state: got state=%0d busy=%0b ready=%0b expected 0 0 0", s_dbg_state, s_busy, s_pix_ready); end
        s_exp_q.delete();
        @(negedge clk);
        s_rst_n = 1'b1;
        #1;
        n_checks++; if (s_pix_ready !== 1'b1) begin n_errors++; $display("FAIL rmc_release_ready: got %0b expected 1", s_pix_ready); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (s_fb_we !== 1'b0 || s_dbg_state !== 2'(ST_IDLE)) begin
            n_errors++; $display("FAIL rmc_after: got we=%0b state=%0d expected 0 0", s_fb_we, s_dbg_state); end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_errors++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0;
        pix_valid = 1'b0; pix_x = 0; pix_y = 0; pix_color = '0; pix_last = 1'b0;
        clear_start = 1'b0; fb_ready = 1'b1;
        s_pix_valid = 1'b0; s_pix_x = 0; s_pix_y = 0; s_pix_color = '0; s_pix_last = 1'b0;
        s_clear_start = 1'b0; s_fb_ready = 1'b1;
        #12;
        s_rst_n = 1'b1;
        test_reset();
        test_single_pixel();
        test_clipping();
        test_backpressure();
        test_back_to_back();
        test_random_mix();
        test_clear_in_draw();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
